// File: rtl/bus_arbiter4.sv
// bus_arbiter4: four-requester round-robin bus arbiter with per-owner hold
// timeout, one dead cycle between owners and registered one-hot grants.
module bus_arbiter4 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       REQ2,
    input  logic       REQ3,
    output logic       GNT0,
    output logic       GNT1,
    output logic       GNT2,
    output logic       GNT3,
    output logic       GNT0_N,
    output logic       GNT1_N,
    output logic       GNT2_N,
    output logic       GNT3_N,
    output logic [1:0] OWNER,
    output logic       BUSY,
    output logic       TIMEOUT
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] owner_q, owner_d, ptr_q, ptr_d, win;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d, found, hold_hit;
    logic [3:0] req;

    assign req      = {REQ3, REQ2, REQ1, REQ0};
    assign hold_hit = (MAX_HOLD != 0) && (cnt_q == 8'(MAX_HOLD));

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr_q + 2'(i)]) begin
                found = 1'b1;
                win   = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == GRANT) begin
            // A dropped request beats the hold limit, so TIMEOUT follows the request.
            if (!req[owner_q] || hold_hit) begin
                state_d   = RELEASE;
                gnt_d     = 4'b0000;
                ptr_d     = owner_q + 2'd1;
                timeout_d = req[owner_q];
            end else begin
                cnt_d = cnt_q + 8'(cnt_q != 8'hff);
            end
        end else if (found) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << win;
            owner_d = win;
            cnt_d   = 8'd1;
        end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            owner_q   <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign {GNT3, GNT2, GNT1, GNT0}         = gnt_q;
    assign {GNT3_N, GNT2_N, GNT1_N, GNT0_N} = ~gnt_q;
    assign OWNER   = owner_q;
    assign BUSY    = (state_q == GRANT);
    assign TIMEOUT = timeout_q;
endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 15, maximum consecutive grant cycles per owner; 0 disables timeout; legal range 0..255.
REQ-002 Port CLK  input  1  system clock; all state changes on posedge CLK.
REQ-003 Port CLR_N  input  1  reset, asynchronous, active-low.
REQ-004 Port REQ0, REQ1, REQ2, REQ3  input  1 each  bus requests, active-high, level-sensitive.
REQ-005 Port GNT0, GNT1, GNT2, GNT3  output  1 each  registered grants, active-high, at most one high.
REQ-006 Port GNT0_N, GNT1_N, GNT2_N, GNT3_N  output  1 each  registered complements of GNT0..GNT3.
REQ-007 Port OWNER  output  2  index of the current or most recent owner.
REQ-008 Port BUSY  output  1  high while any grant is asserted.
REQ-009 Port TIMEOUT  output  1  one-cycle registered pulse on forced release.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT, RELEASE.
REQ-011 IDLE and RELEASE SHALL arbitrate: if any REQ is high at the edge, grant the first requester in search order PTR, PTR+1, PTR+2, PTR+3 (mod 4); next state GRANT.
REQ-012 If no REQ is high in IDLE or RELEASE, next state SHALL be IDLE and all grants SHALL stay low.
REQ-013 Latency: GNTx SHALL rise on the same edge that samples REQx high during arbitration (one edge from REQ to GNT).
REQ-014 On entering GRANT, OWNER SHALL load the winner index and the 8-bit hold counter SHALL load 1.
REQ-015 In GRANT, if REQ[OWNER] is low at the edge, the grant SHALL drop on that edge; next state RELEASE; TIMEOUT stays low.
REQ-016 In GRANT with MAX_HOLD != 0, if REQ[OWNER] is high and the hold counter equals MAX_HOLD, the grant SHALL drop on that edge; next state RELEASE; TIMEOUT high for exactly that one cycle.
REQ-017 Otherwise in GRANT, the grant SHALL hold and the hold counter SHALL increment, saturating at 255.
REQ-018 Every transition GRANT->RELEASE SHALL set PTR = (OWNER+1) mod 4; PTR SHALL be unchanged otherwise.
REQ-019 RELEASE SHALL last exactly one cycle with all grants low, guaranteeing one dead cycle between owners.
REQ-020 Requests from non-owners during GRANT SHALL be ignored until arbitration; no pre-emption.
REQ-021 GNTx_N SHALL equal the inverse of GNTx in every cycle, including during reset.
REQ-022 BUSY SHALL be high iff state is GRANT; OWNER SHALL hold its value through RELEASE and IDLE.
REQ-023 With MAX_HOLD = 1, each grant SHALL last exactly one cycle while the request stays high.

Reset
REQ-024 CLR_N low SHALL immediately, without a clock, force: state IDLE, GNT0..3 = 0, GNT0_N..3_N = 1, OWNER = 0, PTR = 0, hold counter = 0, BUSY = 0, TIMEOUT = 0.
REQ-025 Reset asserted mid-grant SHALL drop the grant asynchronously and discard the grant in progress.
REQ-026 After CLR_N rises, the first posedge CLK SHALL arbitrate normally from PTR = 0.

Verification
REQ-027 Async reset: hold REQ0..3 = 1111 with CLR_N pulsed low between edges -> GNT = 0000, GNT_N = 1111, BUSY = 0 before the next edge.
REQ-028 Single requester: REQ2 rises before edge k -> GNT2 = 1, OWNER = 2, BUSY = 1 after edge k; REQ2 falls before edge k+3 -> GNT2 = 0 after k+3, RELEASE cycle, PTR = 3.
REQ-029 Timeout rotation: MAX_HOLD = 4, REQ0..3 held high -> grant order 0,1,2,3,0, each 4 cycles, one dead cycle between owners, TIMEOUT pulse on each drop.
REQ-030 Round-robin order: owner 1 releases with REQ0 and REQ3 pending -> next grant GNT3, then GNT0 after REQ3 drops.
REQ-031 Timeout disabled: MAX_HOLD = 0, REQ1 held for 300 cycles -> GNT1 high continuously, counter saturates at 255, TIMEOUT never asserts.
REQ-032 Simultaneous events: REQ[OWNER] drops on the edge where the counter equals MAX_HOLD -> release with TIMEOUT = 0, because the request drop takes priority.
